// File: rtl/chain_probe_pkg.sv
// Shared types and helpers for the flop-chain probe sequencer.
package chain_probe_pkg;

    localparam int unsigned DEF_PAT_LEN = 8;
    localparam int unsigned DEF_LAT     = 3;
    localparam int unsigned DEF_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One delay-line slot: whether a real bit is in flight and its expected chain output.
    typedef struct packed {
        logic vld;
        logic exp_bit;
    } probe_tag_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/chain_probe_delay.sv
// LAT-deep shift register that tracks expected chain output alongside the chain under test.
module chain_probe_delay
    import chain_probe_pkg::*;
#(
    parameter int unsigned LAT = DEF_LAT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  probe_tag_t push,
    output probe_tag_t tap
);

    probe_tag_t [LAT-1:0] sr;

    generate
        if (LAT > 1) begin : g_deep
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else begin
                    sr <= {sr[LAT-2:0], push};
                end
            end
        end else begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else begin
                    sr[0] <= push;
                end
            end
        end
    endgenerate

    assign tap = sr[LAT-1];

endmodule

// File: rtl/chain_probe_sequencer.sv
// Serially drives a captured pattern through a flop chain and checks its output after LAT cycles.
module chain_probe_sequencer
    import chain_probe_pkg::*;
#(
    parameter int unsigned PAT_LEN = DEF_PAT_LEN,
    parameter int unsigned LAT     = DEF_LAT,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned IDX_W   = $clog2(PAT_LEN)
) (
    input  logic               I1470_clk,
    input  logic               I1477_rst,
    input  logic               start,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               expect_inv,
    input  logic               chain_out,
    output logic               chain_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_count,
    output logic [IDX_W-1:0]   first_err_idx,
    output logic               first_err_vld
);

    localparam int unsigned FL_W    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]   cmp_idx;
    logic [FL_W-1:0]    flush_cnt;
    logic [PAT_LEN-1:0] pat_q;
    logic               inv_q;

    logic               accept_c;
    logic               mismatch_c;
    logic               chain_in_c;
    logic               busy_c;
    logic               done_c;
    logic               finish_c;
    logic [CNT_W-1:0]   err_nxt_c;
    probe_tag_t         push_c;
    probe_tag_t         tap;

    chain_probe_delay #(
        .LAT (LAT)
    ) u_delay (
        .clk   (I1470_clk),
        .rst_n (I1477_rst),
        .push  (push_c),
        .tap   (tap)
    );

    // State register
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_DRIVE;
            ST_DRIVE: if (bit_cnt == IDX_W'(PAT_LEN - 1)) state_nxt = ST_FLUSH;
            ST_FLUSH: if (flush_cnt == FL_W'(LAT - 1)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = start ? ST_DRIVE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output / datapath control, evaluated ahead of the output registers
    always_comb begin
        accept_c   = 1'b0;
        chain_in_c = 1'b0;
        push_c     = '0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        finish_c   = 1'b0;
        mismatch_c = 1'b0;
        err_nxt_c  = err_count;

        accept_c = start && ((state == ST_IDLE) || (state == ST_DONE));
        if (state == ST_DRIVE) begin
            chain_in_c     = pat_q[bit_cnt];
            push_c.vld     = 1'b1;
            push_c.exp_bit = pat_q[bit_cnt] ^ inv_q;
        end
        busy_c   = (state_nxt == ST_DRIVE) || (state_nxt == ST_FLUSH);
        done_c   = (state_nxt == ST_DONE);
        finish_c = (state == ST_FLUSH) && (state_nxt == ST_DONE);

        mismatch_c = tap.vld && (chain_out != tap.exp_bit);
        if (mismatch_c) begin
            err_nxt_c = CNT_W'(sat_inc(32'(err_count), CNT_MAX));
        end
    end

    // Counters, capture and result registers
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            bit_cnt       <= '0;
            cmp_idx       <= '0;
            flush_cnt     <= '0;
            pat_q         <= '0;
            inv_q         <= 1'b0;
            chain_in      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else begin
            chain_in <= chain_in_c;
            busy     <= busy_c;
            done     <= done_c;

            if (state == ST_DRIVE) begin
                bit_cnt <= IDX_W'(bit_cnt + 1'b1);
            end
            if (state == ST_FLUSH) begin
                flush_cnt <= FL_W'(flush_cnt + 1'b1);
            end else begin
                flush_cnt <= '0;
            end

            if (accept_c) begin
                bit_cnt       <= '0;
                cmp_idx       <= '0;
                pat_q         <= pattern;
                inv_q         <= expect_inv;
                pass          <= 1'b0;
                err_count     <= '0;
                first_err_idx <= '0;
                first_err_vld <= 1'b0;
            end else begin
                err_count <= err_nxt_c;
                if (tap.vld) begin
                    cmp_idx <= IDX_W'(cmp_idx + 1'b1);
                end
                if (mismatch_c && !first_err_vld) begin
                    first_err_idx <= cmp_idx;
                    first_err_vld <= 1'b1;
                end
                // Final compare lands on the same edge that enters DONE
                if (finish_c) begin
                    pass <= (err_nxt_c == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_chain_probe_sequencer.sv
// Directed bench for chain_probe_sequencer against a behavioral inverting flop chain.
module tb_chain_probe_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic       expect_inv = 1'b0;
    logic       chain_out;
    logic       chain_in, busy, done, pass, first_err_vld;
    logic [3:0] err_count;
    logic [2:0] first_err_idx;

    logic       s_start = 1'b0;
    logic [7:0] s_pattern = 8'h00;
    logic       s_inv = 1'b0;
    logic       s_chain_out = 1'b0;
    logic       s_chain_in, s_busy, s_done, s_pass, s_vld;
    logic [1:0] s_err;
    logic [2:0] s_idx;

    logic stuck = 1'b0;
    logic fault = 1'b0;
    logic ca, cb;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // chain_in's own register is the first of the three chain flops; this adds the other two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ca <= 1'b0;
            cb <= 1'b0;
        end else begin
            ca <= ~chain_in ^ fault;
            cb <= ca;
        end
    end
    assign chain_out = stuck ? 1'b0 : cb;

    chain_probe_sequencer dut (
        .I1470_clk     (clk),
        .I1477_rst     (rst_n),
        .start         (start),
        .pattern       (pattern),
        .expect_inv    (expect_inv),
        .chain_out     (chain_out),
        .chain_in      (chain_in),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .first_err_vld (first_err_vld)
    );

    chain_probe_sequencer #(.CNT_W(2)) dut_sat (
        .I1470_clk     (clk),
        .I1477_rst     (rst_n),
        .start         (s_start),
        .pattern       (s_pattern),
        .expect_inv    (s_inv),
        .chain_out     (s_chain_out),
        .chain_in      (s_chain_in),
        .busy          (s_busy),
        .done          (s_done),
        .pass          (s_pass),
        .err_count     (s_err),
        .first_err_idx (s_idx),
        .first_err_vld (s_vld)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] pat, input logic inv);
        pattern    = pat;
        expect_inv = inv;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int from_edge, output int at_edge);
        at_edge = -1;
        for (int k = from_edge + 1; k <= from_edge + 30; k++) begin
            tick();
            if ((sel ? s_done : done) === 1'b1) begin
                at_edge = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        rst_n = 1'b0;
        tick();
        tick();
        obs = {chain_in, busy, done, pass, err_count, first_err_idx, first_err_vld};
        n_vec++;
        if (obs !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_values: got %h expected 0", obs);
        end
        rst_n = 1'b1;
        tick();
        tick();
        obs = {chain_in, busy, done, pass, err_count, first_err_idx, first_err_vld};
        n_vec++;
        if (obs !== 13'd0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %h expected 0", obs);
        end
        n_vec++;
        if ({s_chain_in, s_busy, s_done, s_pass, s_err, s_idx, s_vld} !== 10'd0) begin
            n_bad++;
            $display("FAIL sat_reset_values: got %h expected 0",
                     {s_chain_in, s_busy, s_done, s_pass, s_err, s_idx, s_vld});
        end
    endtask

    task automatic test_nominal();
        logic [7:0] pat;
        logic       exp_ci;
        pat = 8'hA5;
        launch(pat, 1'b1);
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL nominal_busy_edge0: got %b expected 1", busy);
        end
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_ci = (k <= 8) ? pat[k-1] : 1'b0;
            n_vec++;
            if (chain_in !== exp_ci) begin
                n_bad++;
                $display("FAIL nominal_chain_in e%0d: got %b expected %b", k, chain_in, exp_ci);
            end
            n_vec++;
            if (busy !== (k <= 10)) begin
                n_bad++;
                $display("FAIL nominal_busy e%0d: got %b expected %b", k, busy, (k <= 10));
            end
            n_vec++;
            if (done !== (k == 11)) begin
                n_bad++;
                $display("FAIL nominal_done e%0d: got %b expected %b", k, done, (k == 11));
            end
            if (k == 11 || k == 14) begin
                n_vec++;
                if ({pass, err_count, first_err_idx, first_err_vld} !== {1'b1, 4'd0, 3'd0, 1'b0}) begin
                    n_bad++;
                    $display("FAIL nominal_result e%0d: got pass=%b err=%0d idx=%0d vld=%b expected pass=1 err=0 idx=0 vld=0",
                             k, pass, err_count, first_err_idx, first_err_vld);
                end
            end
        end
    endtask

    task automatic test_single_flip();
        int at;
        launch(8'hA5, 1'b1);
        tick();
        tick();
        tick();
        fault = 1'b1;
        tick();
        fault = 1'b0;
        wait_done(1'b0, 4, at);
        n_vec++;
        if (at != 11) begin
            n_bad++;
            $display("FAIL flip_done_edge: got %0d expected 11", at);
        end
        n_vec++;
        if ({pass, err_count, first_err_idx, first_err_vld} !== {1'b0, 4'd1, 3'd2, 1'b1}) begin
            n_bad++;
            $display("FAIL flip_result: got pass=%b err=%0d idx=%0d vld=%b expected pass=0 err=1 idx=2 vld=1",
                     pass, err_count, first_err_idx, first_err_vld);
        end
    endtask

    task automatic test_stuck_zero();
        int at;
        stuck = 1'b1;
        launch(8'hA5, 1'b1);
        wait_done(1'b0, 0, at);
        stuck = 1'b0;
        n_vec++;
        if (at != 11) begin
            n_bad++;
            $display("FAIL stuck_done_edge: got %0d expected 11", at);
        end
        n_vec++;
        if ({pass, err_count, first_err_idx, first_err_vld} !== {1'b0, 4'd4, 3'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL stuck_result: got pass=%b err=%0d idx=%0d vld=%b expected pass=0 err=4 idx=1 vld=1",
                     pass, err_count, first_err_idx, first_err_vld);
        end
    endtask

    task automatic test_start_while_busy();
        int at;
        int extra;
        stuck = 1'b1;
        launch(8'hA5, 1'b1);
        tick();
        tick();
        pattern    = 8'h00;
        expect_inv = 1'b0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        tick();
        tick();
        start      = 1'b1;
        tick();
        start      = 1'b0;
        wait_done(1'b0, 6, at);
        n_vec++;
        if (at != 11) begin
            n_bad++;
            $display("FAIL busy_start_done_edge: got %0d expected 11", at);
        end
        n_vec++;
        if ({pass, err_count, first_err_idx, first_err_vld} !== {1'b0, 4'd4, 3'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL busy_start_result: got pass=%b err=%0d idx=%0d vld=%b expected pass=0 err=4 idx=1 vld=1",
                     pass, err_count, first_err_idx, first_err_vld);
        end
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done === 1'b1) extra++;
        end
        stuck = 1'b0;
        n_vec++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL busy_start_extra_done: got %0d expected 0", extra);
        end
    endtask

    task automatic test_reset_mid_run();
        int          at;
        int          seen;
        logic [12:0] obs;
        launch(8'hA5, 1'b1);
        tick();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        obs = {chain_in, busy, done, pass, err_count, first_err_idx, first_err_vld};
        n_vec++;
        if (obs !== 13'd0) begin
            n_bad++;
            $display("FAIL midrst_async_clear: got %h expected 0", obs);
        end
        seen = 0;
        tick();
        if (done === 1'b1) seen++;
        tick();
        if (done === 1'b1) seen++;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen);
        end
        launch(8'h3C, 1'b1);
        wait_done(1'b0, 0, at);
        n_vec++;
        if (at != 11) begin
            n_bad++;
            $display("FAIL midrst_rerun_edge: got %0d expected 11", at);
        end
        n_vec++;
        if ({pass, err_count, first_err_idx, first_err_vld} !== {1'b1, 4'd0, 3'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL midrst_rerun_result: got pass=%b err=%0d idx=%0d vld=%b expected pass=1 err=0 idx=0 vld=0",
                     pass, err_count, first_err_idx, first_err_vld);
        end
    endtask

    task automatic test_saturate();
        int at;
        s_pattern   = 8'hFF;
        s_inv       = 1'b0;
        s_chain_out = 1'b0;
        s_start     = 1'b1;
        tick();
        s_start     = 1'b0;
        wait_done(1'b1, 0, at);
        n_vec++;
        if (at != 11) begin
            n_bad++;
            $display("FAIL sat_done_edge: got %0d expected 11", at);
        end
        n_vec++;
        if ({s_pass, s_err, s_idx, s_vld} !== {1'b0, 2'd3, 3'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL sat_result: got pass=%b err=%0d idx=%0d vld=%b expected pass=0 err=3 idx=0 vld=1",
                     s_pass, s_err, s_idx, s_vld);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_single_flip();
        test_stuck_zero();
        test_start_while_busy();
        test_reset_mid_run();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/chain_probe_sequencer.md
# chain_probe_sequencer

Sequencer that exercises a flop-chain subcircuit (a DFFARX1 pipeline with optional inversion, the kind extracted as trojan-detection test circuits). It serially drives a captured bit pattern into the chain's data input and samples the chain's output after a fixed latency. It compares each sample against the expected (optionally inverted) bit and reports pass/fail, mismatch count and first failing index. It sits beside the chain under test in a self-checking wrapper, sharing the chain's clock and reset.

## Interface
- PAT_LEN, 8: pattern length in bits (≥2).
- LAT, 3: chain latency in flops from chain_in to chain_out (≥1).
- CNT_W, 4: width of err_count.
- IDX_W, $clog2(PAT_LEN): width of first_err_idx.

Ports:
- I1470_clk  in  1  single clock, rising edge.
- I1477_rst  in  1  asynchronous, active-low reset.
- start  in  1  run request; accepted only in IDLE or DONE.
- pattern  in  PAT_LEN  stimulus bits, captured on start acceptance; bit 0 is driven first.
- expect_inv  in  1  chain inverts odd number of times; captured with pattern.
- chain_out  in  1  output of chain under test.
- chain_in  out  1  registered drive into chain under test.
- busy  out  1  high in DRIVE and FLUSH.
- done  out  1  one-cycle pulse in DONE.
- pass  out  1  valid from done until next accepted start; 1 iff err_count==0.
- err_count  out  CNT_W  mismatch count, saturating.
- first_err_idx  out  IDX_W  index of first mismatching bit; 0 if none.
- first_err_vld  out  1  a mismatch has been recorded this run.

## Operation
- Reset (async assert, sync-free release): state IDLE; chain_in, busy, done, pass, err_count, first_err_idx, first_err_vld all 0; delay line cleared.
- FSM states: IDLE, DRIVE, FLUSH, DONE.
- IDLE/DONE + start: capture pattern and expect_inv, clear err_count, first_err_idx, first_err_vld, pass; go to DRIVE; bit counter = 0.
- DRIVE: each cycle register chain_in = pattern[i], push {valid=1, exp=pattern[i]^expect_inv} into delay line; after i = PAT_LEN-1 go to FLUSH.
- FLUSH: chain_in = 0, push {valid=0}; after LAT cycles go to DONE.
- Compare: whenever the delay-line output has valid=1, compare chain_out to exp; on mismatch increment err_count (hold at 2^CNT_W-1), and if first_err_vld=0 record the bit index and set first_err_vld.
- DONE: done=1 for one cycle, pass = (err_count==0) including the final compare; next cycle IDLE unless start is high (immediate restart allowed).
- start while busy: ignored, no effect on captured pattern or results.
- Results (pass, err_count, first_err_*) hold until the next accepted start.
- chain_in is 0 in IDLE, FLUSH, DONE.

## Timing
- Edge 0: start sampled in IDLE. Bit i launched on chain_in at edge 1+i; sampled from chain_out at edge 1+i+LAT.
- Last compare at edge PAT_LEN+LAT; done high in the cycle after it; total run = PAT_LEN+LAT+1 cycles start-to-done.
- Defaults: launch edges 1–8, compares at edges 4–11, done between edges 11 and 12.
- busy rises after edge 0, falls after edge PAT_LEN+LAT.
- Reset asserted mid-run: immediate return to reset values; no done pulse; no partial results retained.
- Mismatch on the final compare edge is counted and reflected in pass at done.

## Structure
- Package chain_probe_pkg: state enum (IDLE, DRIVE, FLUSH, DONE), default parameter constants, saturating-increment function.
- Sub-module chain_probe_delay: LAT-deep shift register of {valid, exp}, async active-low reset to zero; instantiated once.
- Top holds FSM, bit counter (IDX_W), flush counter, capture registers and result registers.

## Test plan
- Default params, behavioral 3-flop inverting chain, pattern 8'hA5, expect_inv=1, start at edge 0 -> done at cycle after edge 11, pass=1, err_count=0, first_err_vld=0.
- Same, chain model flips bit 2 only -> pass=0, err_count=1, first_err_idx=2, first_err_vld=1.
- chain_out stuck at 0, pattern 8'hA5, expect_inv=1 -> err_count=4, first_err_idx=1, pass=0.
- CNT_W=2, chain_out = ~expected always -> err_count saturates at 3, first_err_idx=0.
- start pulsed at edges 3 and 6 of a run -> ignored; single done at edge 11 result, results match first pattern.
- I1477_rst low at edge 5 for 2 cycles -> all outputs 0, no done; new start afterwards runs a full clean 12-cycle sequence.
